// File: rtl/decode_pkg.sv
// Shared constants, the ID/EX pipeline record and the immediate extender for the decode stage.
package decode_pkg;

    localparam int unsigned DefWidth       = 32;
    localparam int unsigned DefRegNum      = 16;
    localparam int unsigned DefAddressWidth = 4;
    localparam int unsigned DefImmWidth    = 12;
    localparam int unsigned DefPcReg       = DefRegNum - 1;

    // ID/EX record; field widths follow the package defaults.
    typedef struct packed {
        logic                       valid;
        logic [DefWidth-1:0]        op1;
        logic [DefWidth-1:0]        op2;
        logic [DefWidth-1:0]        storeData;
        logic [DefWidth-1:0]        imm;
        logic [DefAddressWidth-1:0] dest;
        logic                       isLoad;
        logic                       regWrite;
    } id_ex_t;

    function automatic logic [DefWidth-1:0] extend_imm(input logic [DefImmWidth-1:0] raw,
                                                       input logic is_signed);
        logic fill;
        fill = is_signed & raw[DefImmWidth-1];
        return {{(DefWidth-DefImmWidth){fill}}, raw};
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Two-read/one-write register file with a PC+8 alias register and write-through bypass.
module regfile_bypass
    import decode_pkg::*;
#(
    parameter int unsigned WIDTH        = DefWidth,
    parameter int unsigned REGNUM       = DefRegNum,
    parameter int unsigned ADDRESSWIDTH = DefAddressWidth,
    parameter int unsigned PCREG        = REGNUM - 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDRESSWIDTH-1:0] rd_addr1,
    input  logic [ADDRESSWIDTH-1:0] rd_addr2,
    input  logic [WIDTH-1:0]        pc_plus8,
    input  logic                    wb_enable,
    input  logic [ADDRESSWIDTH-1:0] wb_address,
    input  logic [WIDTH-1:0]        wb_data,
    output logic [WIDTH-1:0]        rd_data1,
    output logic [WIDTH-1:0]        rd_data2
);

    localparam logic [ADDRESSWIDTH-1:0] PcAddr = ADDRESSWIDTH'(PCREG);

    logic [WIDTH-1:0]        regs [REGNUM];
    logic [ADDRESSWIDTH-1:0] rd_addr [2];
    logic [WIDTH-1:0]        rd_data [2];
    logic                    wb_in_range;

    assign rd_addr[0]  = rd_addr1;
    assign rd_addr[1]  = rd_addr2;
    assign rd_data1    = rd_data[0];
    assign rd_data2    = rd_data[1];
    assign wb_in_range = 32'(wb_address) < REGNUM;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(REGNUM); i++) begin
                regs[i] <= '0;
            end
        end else if (wb_enable && wb_in_range && wb_address != PcAddr) begin
            regs[wb_address] <= wb_data;
        end
    end

    // Priority: PC alias, then out-of-range zero, then same-cycle writeback, then storage.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            if (rd_addr[p] == PcAddr) begin
                rd_data[p] = pc_plus8;
            end else if (32'(rd_addr[p]) >= REGNUM) begin
                rd_data[p] = '0;
            end else if (wb_enable && wb_address == rd_addr[p]) begin
                rd_data[p] = wb_data;
            end else begin
                rd_data[p] = regs[rd_addr[p]];
            end
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode: operand read and select, immediate extension, load-use detection and
// the ID/EX pipeline register with flush/stall/bubble control.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned WIDTH        = DefWidth,
    parameter int unsigned REGNUM       = DefRegNum,
    parameter int unsigned ADDRESSWIDTH = DefAddressWidth,
    parameter int unsigned IMMWIDTH     = DefImmWidth,
    parameter int unsigned PCREG        = REGNUM - 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    inValid,
    input  logic [ADDRESSWIDTH-1:0] reg1Address,
    input  logic [ADDRESSWIDTH-1:0] reg2Address,
    input  logic [ADDRESSWIDTH-1:0] destAddress,
    input  logic [IMMWIDTH-1:0]     immediate,
    input  logic                    immSigned,
    input  logic                    useImm,
    input  logic                    isLoad,
    input  logic                    regWriteReq,
    input  logic [WIDTH-1:0]        pcPlus8,
    input  logic                    wbEnable,
    input  logic [ADDRESSWIDTH-1:0] wbAddress,
    input  logic [WIDTH-1:0]        wbData,
    input  logic                    stall,
    input  logic                    flush,
    output logic                    holdUpstream,
    output logic                    outValid,
    output logic [WIDTH-1:0]        outOp1,
    output logic [WIDTH-1:0]        outOp2,
    output logic [WIDTH-1:0]        outStoreData,
    output logic [WIDTH-1:0]        outImm,
    output logic [ADDRESSWIDTH-1:0] outDest,
    output logic                    outIsLoad,
    output logic                    outRegWrite
);

    localparam logic [ADDRESSWIDTH-1:0] PcAddr = ADDRESSWIDTH'(PCREG);

    id_ex_t           id_ex_q, id_ex_d;
    logic [WIDTH-1:0] read1, read2, imm_ext;
    logic             load_use;

    regfile_bypass #(
        .WIDTH        (WIDTH),
        .REGNUM       (REGNUM),
        .ADDRESSWIDTH (ADDRESSWIDTH),
        .PCREG        (PCREG)
    ) u_regfile (
        .clock      (clock),
        .reset      (reset),
        .rd_addr1   (reg1Address),
        .rd_addr2   (reg2Address),
        .pc_plus8   (pcPlus8),
        .wb_enable  (wbEnable),
        .wb_address (wbAddress),
        .wb_data    (wbData),
        .rd_data1   (read1),
        .rd_data2   (read2)
    );

    assign imm_ext = extend_imm(immediate, immSigned);

    // A load writing the PC alias never produces a dependency: reads of PCREG see pcPlus8.
    assign load_use = inValid & id_ex_q.valid & id_ex_q.isLoad & id_ex_q.regWrite &
                      (id_ex_q.dest != PcAddr) &
                      ((reg1Address == id_ex_q.dest) | (!useImm & (reg2Address == id_ex_q.dest)));

    assign holdUpstream = stall | load_use;

    always_comb begin
        id_ex_d = '0;
        if (flush) begin
            id_ex_d = '0;
        end else if (stall) begin
            id_ex_d = id_ex_q;
        end else if (load_use) begin
            id_ex_d = '0;
        end else begin
            id_ex_d.valid     = inValid;
            id_ex_d.op1       = read1;
            id_ex_d.op2       = useImm ? imm_ext : read2;
            id_ex_d.storeData = read2;
            id_ex_d.imm       = imm_ext;
            id_ex_d.dest      = destAddress;
            id_ex_d.isLoad    = isLoad;
            id_ex_d.regWrite  = regWriteReq;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign outValid     = id_ex_q.valid;
    assign outOp1       = id_ex_q.op1;
    assign outOp2       = id_ex_q.op2;
    assign outStoreData = id_ex_q.storeData;
    assign outImm       = id_ex_q.imm;
    assign outDest      = id_ex_q.dest;
    assign outIsLoad    = id_ex_q.isLoad;
    assign outRegWrite  = id_ex_q.regWrite;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected ID/EX records are queued when stimulus is driven
// and compared one cycle later.
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        inValid;
    logic [3:0]  reg1Address, reg2Address, destAddress;
    logic [11:0] immediate;
    logic        immSigned, useImm, isLoad, regWriteReq;
    logic [31:0] pcPlus8;
    logic        wbEnable;
    logic [3:0]  wbAddress;
    logic [31:0] wbData;
    logic        stall, flush;
    logic        holdUpstream, outValid, outIsLoad, outRegWrite;
    logic [31:0] outOp1, outOp2, outStoreData, outImm;
    logic [3:0]  outDest;

    typedef struct packed {
        logic        full;
        logic        valid;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] sd;
        logic [31:0] imm;
        logic [3:0]  dest;
        logic        ld;
        logic        rw;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    decode_stage dut (
        .clock        (clock),
        .reset        (reset),
        .inValid      (inValid),
        .reg1Address  (reg1Address),
        .reg2Address  (reg2Address),
        .destAddress  (destAddress),
        .immediate    (immediate),
        .immSigned    (immSigned),
        .useImm       (useImm),
        .isLoad       (isLoad),
        .regWriteReq  (regWriteReq),
        .pcPlus8      (pcPlus8),
        .wbEnable     (wbEnable),
        .wbAddress    (wbAddress),
        .wbData       (wbData),
        .stall        (stall),
        .flush        (flush),
        .holdUpstream (holdUpstream),
        .outValid     (outValid),
        .outOp1       (outOp1),
        .outOp2       (outOp2),
        .outStoreData (outStoreData),
        .outImm       (outImm),
        .outDest      (outDest),
        .outIsLoad    (outIsLoad),
        .outRegWrite  (outRegWrite)
    );

    task automatic drive(input logic v, input logic [3:0] r1, input logic [3:0] r2,
                         input logic [3:0] dst, input logic [11:0] im, input logic sg,
                         input logic ui, input logic ld, input logic rw, input logic [31:0] pc);
        inValid = v; reg1Address = r1; reg2Address = r2; destAddress = dst;
        immediate = im; immSigned = sg; useImm = ui; isLoad = ld; regWriteReq = rw;
        pcPlus8 = pc;
    endtask

    task automatic wb(input logic en, input logic [3:0] a, input logic [31:0] d);
        wbEnable = en; wbAddress = a; wbData = d;
    endtask

    task automatic expect_full(input logic v, input logic [31:0] op1, input logic [31:0] op2,
                               input logic [31:0] sd, input logic [31:0] imm,
                               input logic [3:0] dest, input logic ld, input logic rw);
        sb.push_back('{1'b1, v, op1, op2, sd, imm, dest, ld, rw});
    endtask

    task automatic expect_invalid();
        sb.push_back('{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0});
    endtask

    task automatic compare(input string tag);
        exp_t e;
        exp_t o;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL %s: scoreboard empty, nothing expected", tag);
        end else begin
            e = sb.pop_front();
            o = '{e.full, outValid, outOp1, outOp2, outStoreData, outImm, outDest, outIsLoad,
                  outRegWrite};
            if (e.full) begin
                assert (o === e) else begin
                    failures++;
                    $error("FAIL %s: observed v=%b op1=%h op2=%h sd=%h imm=%h dst=%h ld=%b rw=%b expected v=%b op1=%h op2=%h sd=%h imm=%h dst=%h ld=%b rw=%b",
                           tag, o.valid, o.op1, o.op2, o.sd, o.imm, o.dest, o.ld, o.rw,
                           e.valid, e.op1, e.op2, e.sd, e.imm, e.dest, e.ld, e.rw);
                end
            end else begin
                assert (o.valid === e.valid) else begin
                    failures++;
                    $error("FAIL %s: observed outValid=%b expected %b", tag, o.valid, e.valid);
                end
            end
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        @(negedge clock);
        compare(tag);
    endtask

    task automatic check_hold(input string tag, input logic e);
        #1;
        checks++;
        assert (holdUpstream === e) else begin
            failures++;
            $error("FAIL %s: observed holdUpstream=%b expected %b", tag, holdUpstream, e);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 4'd1, 4'd2, 4'd9, 12'h7FF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
        wb(1'b1, 4'd2, 32'h1111_1111);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        wb(1'b0, 4'd0, 32'h0);
        drive(1'b0, 4'd0, 4'd0, 4'd0, 12'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        expect_full(1'b0, 0, 0, 0, 0, 4'd0, 1'b0, 1'b0);
        compare("reset_outputs");
        check_hold("reset_hold", 1'b0);

        // Registers cleared by reset (the write during reset must not stick)
        drive(1'b1, 4'd1, 4'd2, 4'd1, 12'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
        expect_full(1'b1, 0, 0, 0, 0, 4'd1, 1'b0, 1'b1);
        tick("read_after_reset");

        // Write-through bypass, then the stored value
        wb(1'b1, 4'd3, 32'hDEAD_BEEF);
        drive(1'b1, 4'd3, 4'd0, 4'd4, 12'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h104);
        expect_full(1'b1, 32'hDEAD_BEEF, 0, 0, 0, 4'd4, 1'b0, 1'b1);
        tick("bypass_r3");
        wb(1'b0, 4'd0, 32'h0);
        drive(1'b1, 4'd0, 4'd3, 4'd4, 12'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h108);
        expect_full(1'b1, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 4'd4, 1'b0, 1'b1);
        tick("stored_r3");

        // PC alias: writes to r15 ignored, reads give pcPlus8
        wb(1'b1, 4'd15, 32'h1234_5678);
        drive(1'b1, 4'd15, 4'd0, 4'd2, 12'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h108);
        expect_full(1'b1, 32'h108, 0, 0, 0, 4'd2, 1'b0, 1'b0);
        tick("pcreg_alias_during_write");
        wb(1'b0, 4'd0, 32'h0);
        drive(1'b1, 4'd15, 4'd15, 4'd2, 12'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200);
        expect_full(1'b1, 32'h200, 32'h200, 32'h200, 0, 4'd2, 1'b0, 1'b0);
        tick("pcreg_alias_after_write");

        // Immediate extension; storeData stays reg2
        wb(1'b1, 4'd7, 32'h0000_0055);
        drive(1'b1, 4'd3, 4'd7, 4'd8, 12'h800, 1'b1, 1'b1, 1'b0, 1'b1, 32'h20C);
        expect_full(1'b1, 32'hDEAD_BEEF, 32'hFFFF_F800, 32'h55, 32'hFFFF_F800, 4'd8, 1'b0, 1'b1);
        tick("imm_signed");
        wb(1'b0, 4'd0, 32'h0);
        drive(1'b1, 4'd3, 4'd7, 4'd8, 12'h800, 1'b0, 1'b1, 1'b0, 1'b1, 32'h210);
        expect_full(1'b1, 32'hDEAD_BEEF, 32'h0000_0800, 32'h55, 32'h0000_0800, 4'd8, 1'b0, 1'b1);
        tick("imm_unsigned");

        // Load-use on reg1: one bubble, then the instruction proceeds
        drive(1'b1, 4'd0, 4'd0, 4'd5, 12'h004, 1'b1, 1'b1, 1'b1, 1'b1, 32'h214);
        expect_full(1'b1, 0, 32'h4, 0, 32'h4, 4'd5, 1'b1, 1'b1);
        tick("load_r5");
        drive(1'b1, 4'd5, 4'd0, 4'd6, 12'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h218);
        check_hold("load_use_hold", 1'b1);
        wb(1'b1, 4'd5, 32'hA5A5_A5A5);
        expect_invalid();
        tick("load_use_bubble");
        wb(1'b0, 4'd0, 32'h0);
        check_hold("load_use_cleared", 1'b0);
        expect_full(1'b1, 32'hA5A5_A5A5, 0, 0, 0, 4'd6, 1'b0, 1'b1);
        tick("load_use_proceeds");

        // Only reg2 matches but useImm=1: no hazard
        drive(1'b1, 4'd0, 4'd0, 4'd5, 12'h004, 1'b1, 1'b1, 1'b1, 1'b1, 32'h21C);
        expect_full(1'b1, 0, 32'h4, 0, 32'h4, 4'd5, 1'b1, 1'b1);
        tick("load_r5_again");
        drive(1'b1, 4'd0, 4'd5, 4'd6, 12'h008, 1'b1, 1'b1, 1'b0, 1'b1, 32'h220);
        check_hold("imm_no_hazard_hold", 1'b0);
        expect_full(1'b1, 0, 32'h8, 32'hA5A5_A5A5, 32'h8, 4'd6, 1'b0, 1'b1);
        tick("imm_no_hazard");

        // Stall for three cycles holds every field
        stall = 1'b1;
        drive(1'b1, 4'd3, 4'd3, 4'd9, 12'h123, 1'b0, 1'b0, 1'b0, 1'b0, 32'h224);
        check_hold("stall_hold", 1'b1);
        for (int i = 0; i < 3; i++) begin
            expect_full(1'b1, 0, 32'h8, 32'hA5A5_A5A5, 32'h8, 4'd6, 1'b0, 1'b1);
            tick("stall_held");
        end

        // Flush beats stall
        flush = 1'b1;
        expect_invalid();
        tick("stall_flush");
        stall = 1'b0; flush = 1'b0;
        drive(1'b1, 4'd7, 4'd0, 4'd1, 12'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h228);
        expect_full(1'b1, 32'h55, 0, 0, 0, 4'd1, 1'b0, 1'b1);
        tick("after_flush");

        // Reset in the middle of a load-use hazard
        drive(1'b1, 4'd0, 4'd0, 4'd5, 12'h004, 1'b1, 1'b1, 1'b1, 1'b1, 32'h22C);
        expect_full(1'b1, 0, 32'h4, 0, 32'h4, 4'd5, 1'b1, 1'b1);
        tick("load_before_reset");
        drive(1'b1, 4'd5, 4'd0, 4'd6, 12'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h230);
        check_hold("hazard_before_reset", 1'b1);
        reset = 1'b1;
        expect_full(1'b0, 0, 0, 0, 0, 4'd0, 1'b0, 1'b0);
        tick("reset_mid_hazard");
        reset = 1'b0;
        drive(1'b0, 4'd0, 4'd0, 4'd0, 12'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_hold("idle_after_reset", 1'b0);
        drive(1'b1, 4'd3, 4'd7, 4'd2, 12'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        expect_full(1'b1, 0, 0, 0, 0, 4'd2, 1'b0, 1'b1);
        tick("regs_cleared_by_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
